// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled tick advances rotate/bounce/blink/count patterns.
// Optional LED_PWM_DIM_EN adds a 4-bit duty input that dims the LED outputs.
module led_pattern_gen #(
    parameter int unsigned      LED_W      = 4,
    parameter int unsigned      CNT_W      = 25,
    parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(7_999_999)
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [2:0]       mode_in,
    input  logic [CNT_W-1:0] period_in,
`ifdef LED_PWM_DIM_EN
    input  logic [3:0]       duty,
`endif
    output logic [LED_W-1:0] led,
    output logic             tick,
    output logic [2:0]       mode
);

    localparam logic [2:0] MODE_ROT_L  = 3'd0;
    localparam logic [2:0] MODE_ROT_R  = 3'd1;
    localparam logic [2:0] MODE_BOUNCE = 3'd2;
    localparam logic [2:0] MODE_BLINK  = 3'd3;
    localparam logic [2:0] MODE_COUNT  = 3'd4;

    localparam logic [LED_W-1:0] MSB_ONLY = {1'b1, {(LED_W-1){1'b0}}};
    localparam logic [LED_W-1:0] LSB_ONLY = LED_W'(1);

    logic [LED_W-1:0] pattern, pattern_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] period_r, period_nxt;
    logic [2:0]       mode_nxt;
    logic             tick_nxt;
    logic             dir, dir_nxt;
    logic             one_hot;
    logic             up;

    // Reserved modes keep whatever is currently displayed.
    function automatic logic [LED_W-1:0] seed_of(input logic [2:0] m,
                                                 input logic [LED_W-1:0] cur);
        case (m)
            MODE_ROT_L:              return MSB_ONLY;
            MODE_ROT_R, MODE_BOUNCE: return LSB_ONLY;
            MODE_BLINK:              return '1;
            MODE_COUNT:              return '0;
            default:                 return cur;
        endcase
    endfunction

    assign one_hot = (pattern != '0) && ((pattern & (pattern - LED_W'(1))) == '0);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern  <= MSB_ONLY;
            cnt      <= '0;
            period_r <= DEF_PERIOD;
            mode     <= MODE_ROT_L;
            tick     <= 1'b0;
            dir      <= 1'b0;
        end else begin
            pattern  <= pattern_nxt;
            cnt      <= cnt_nxt;
            period_r <= period_nxt;
            mode     <= mode_nxt;
            tick     <= tick_nxt;
            dir      <= dir_nxt;
        end
    end

    always_comb begin
        cnt_nxt     = (cnt == period_r) ? '0 : cnt + CNT_W'(1);
        tick_nxt    = (cnt == period_r);
        period_nxt  = period_r;
        mode_nxt    = mode;
        pattern_nxt = pattern;
        dir_nxt     = dir;
        // An end LED always turns the bounce around, whatever dir says.
        up          = pattern[0] | (~dir & ~pattern[LED_W-1]);

        if (load) begin
            mode_nxt    = mode_in;
            period_nxt  = period_in;
            cnt_nxt     = '0;
            tick_nxt    = 1'b0;
            pattern_nxt = seed_of(mode_in, pattern);
            dir_nxt     = 1'b0;
        end else if (tick && en) begin
            case (mode)
                MODE_ROT_L:
                    pattern_nxt = one_hot ? {pattern[LED_W-2:0], pattern[LED_W-1]} : MSB_ONLY;
                MODE_ROT_R:
                    pattern_nxt = one_hot ? {pattern[0], pattern[LED_W-1:1]} : LSB_ONLY;
                MODE_BOUNCE: begin
                    if (!one_hot) begin
                        pattern_nxt = LSB_ONLY;
                        dir_nxt     = 1'b0;
                    end else if (up) begin
                        pattern_nxt = pattern << 1;
                        dir_nxt     = pattern[LED_W-2];
                    end else begin
                        pattern_nxt = pattern >> 1;
                        dir_nxt     = ~pattern[1];
                    end
                end
                MODE_BLINK: pattern_nxt = ~pattern;
                MODE_COUNT: pattern_nxt = pattern + LED_W'(1);
                default:    pattern_nxt = pattern;
            endcase
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= 4'd0;
        else        pwm_cnt <= pwm_cnt + 4'd1;
    end

    assign led = pattern & {LED_W{pwm_cnt < duty}};
`else
    assign led = pattern;
`endif

endmodule
